multi_mode_multiplier_iter: RTL and testbench

- Folded, iterative successor to the single-shot grid multiplier used in the redundant Montgomery datapath.
- Processes ROWS_PER_CYCLE rows of the partial-product grid per cycle into a column accumulator, then carry-normalises the result over several cycles.
- Adds a fourth mode (full product), full valid/ready handshakes on both sides, and an add term on either half.
- Sits between the Montgomery control FSM and the reduction stage; trades latency for DSP count when NUM_ELEMENTS is large.

---
 rtl/mmm_iter_pkg.sv | 64 ++++++
 rtl/redun_carry_prop.sv | 38 +++
 rtl/multi_mode_multiplier_iter.sv | 239 +++++++++++++++++++++++
 tb/tb_multi_mode_multiplier_iter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_iter_pkg.sv
// Shared types and sizing helpers for the folded multi-mode multiplier.
// Partial-product selection and output masking are defined once here.
package mmm_iter_pkg;

  typedef enum logic [1:0] {
    MODE_LOW    = 2'd0,
    MODE_HIGH   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_FULL   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int acc_bit_len(input int dsp_bit_len, input int word_len,
                                     input int num_elements);
    return 2 * dsp_bit_len - word_len + $clog2(2 * num_elements + 2);
  endfunction

  function automatic int num_mul_cycles(input int num_elements, input int rows_per_cycle);
    return (num_elements + rows_per_cycle - 1) / rows_per_cycle;
  endfunction

  function automatic int num_carry_cycles(input int num_elements, input int carry_words);
    return (2 * num_elements + carry_words - 1) / carry_words;
  endfunction

  function automatic int cnt_width(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  function automatic logic pp_included(input mode_e mode, input int i, input int j,
                                       input int n);
    logic inc;
    case (mode)
      MODE_LOW:    inc = (i + j < n);
      MODE_HIGH:   inc = (i + j >= n - 1);
      MODE_SQUARE: inc = (i <= j);
      MODE_FULL:   inc = 1'b1;
      default:     inc = 1'b0;
    endcase
    return inc;
  endfunction

  // In SQUARE only the upper triangle is formed, so mirrored terms count twice.
  function automatic logic pp_doubled(input mode_e mode, input int i, input int j);
    return (mode == MODE_SQUARE) && (i < j);
  endfunction

  function automatic logic word_kept(input mode_e mode, input int w, input int n);
    logic keep;
    case (mode)
      MODE_LOW:  keep = (w < n);
      MODE_HIGH: keep = (w >= n - 1);
      default:   keep = 1'b1;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/redun_carry_prop.sv
// One ripple slice of the carry normaliser: reduces CARRY_WORDS accumulator
// columns to radix words, except the global top word which keeps every bit.
module redun_carry_prop
  import mmm_iter_pkg::*;
#(
  parameter int CARRY_WORDS = 8,
  parameter int ACC_BIT_LEN = 25,
  parameter int WORD_LEN    = 16,
  parameter int DSP_BIT_LEN = 17
) (
  input  logic [CARRY_WORDS-1:0][ACC_BIT_LEN-1:0] i_col,
  input  logic [CARRY_WORDS-1:0]                  i_top,
  input  logic [ACC_BIT_LEN-1:0]                  i_carry,
  output logic [CARRY_WORDS-1:0][DSP_BIT_LEN-1:0] o_word,
  output logic [ACC_BIT_LEN-1:0]                  o_carry
);

  // Ripple the carry through the slice, word 0 first.
  always_comb begin
    logic [ACC_BIT_LEN:0]   sum;
    logic [ACC_BIT_LEN-1:0] carry;
    sum    = '0;
    carry  = i_carry;
    o_word = '0;
    for (int k = 0; k < CARRY_WORDS; k++) begin
      sum = {1'b0, i_col[k]} + {1'b0, carry};
      if (i_top[k]) begin
        o_word[k] = sum[DSP_BIT_LEN-1:0];
        carry     = '0;
      end else begin
        o_word[k] = DSP_BIT_LEN'(sum[WORD_LEN-1:0]);
        carry     = ACC_BIT_LEN'(sum >> WORD_LEN);
      end
    end
    o_carry = carry;
  end

endmodule

// File: rtl/multi_mode_multiplier_iter.sv
// Folded grid multiplier: ROWS_PER_CYCLE rows of A x all of B per MUL cycle into
// a column accumulator, then CARRY_WORDS-wide carry normalisation per CARRY cycle.
module multi_mode_multiplier_iter
  import mmm_iter_pkg::*;
#(
  parameter int NUM_ELEMENTS   = 33,
  parameter int DSP_BIT_LEN    = 17,
  parameter int WORD_LEN       = 16,
  parameter int ROWS_PER_CYCLE = 4,
  parameter int CARRY_WORDS    = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_val,
  output logic                                    o_rdy,
  input  logic [1:0]                              i_ctl,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_dat_a,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_dat_b,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]     i_add_term,
  output logic                                    o_val,
  input  logic                                    i_rdy,
  output logic [DSP_BIT_LEN*2*NUM_ELEMENTS-1:0]   o_dat,
  output logic                                    o_busy
);

  localparam int N      = NUM_ELEMENTS;
  localparam int NCOL   = 2 * NUM_ELEMENTS;
  localparam int DBL    = DSP_BIT_LEN;
  localparam int CW     = CARRY_WORDS;
  localparam int ACC    = acc_bit_len(DSP_BIT_LEN, WORD_LEN, NUM_ELEMENTS);
  localparam int P      = num_mul_cycles(NUM_ELEMENTS, ROWS_PER_CYCLE);
  localparam int C      = num_carry_cycles(NUM_ELEMENTS, CARRY_WORDS);
  localparam int RW     = cnt_width(P);
  localparam int CCW    = cnt_width(C);
  localparam int AIW    = cnt_width(N);
  localparam int CIW    = cnt_width(NCOL);
  localparam int PROD_W = 2 * DSP_BIT_LEN + 1;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [DBL-1:0]   a_q[N], a_d[N];
  logic [DBL-1:0]   b_q[N], b_d[N];
  logic [DBL-1:0]   add_q[N], add_d[N];
  logic [ACC-1:0]   acc_q[NCOL], acc_d[NCOL];
  logic [DBL-1:0]   dat_q[NCOL], dat_d[NCOL];
  logic [RW-1:0]    row_q, row_d;
  logic [CCW-1:0]   cq_q, cq_d;
  logic [ACC-1:0]   carry_q, carry_d;
  logic             rdy_q, rdy_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;

  logic [ACC-1:0]             pp_col[NCOL];
  logic [CW-1:0][ACC-1:0]     slice_col;
  logic [CW-1:0]              slice_top;
  logic [CW-1:0][DBL-1:0]     slice_word;
  logic [ACC-1:0]             slice_carry;

  // Column sums of this pass's partial products; the add term rides on pass 0.
  always_comb begin
    int row;
    logic [PROD_W-1:0] prod;
    row  = 0;
    prod = '0;
    for (int c = 0; c < NCOL; c++) pp_col[c] = '0;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      row = int'(row_q) * ROWS_PER_CYCLE + k;
      for (int j = 0; j < N; j++) begin
        if (row < N && pp_included(mode_q, row, j, N)) begin
          prod = PROD_W'(a_q[AIW'(row)]) * PROD_W'(b_q[j]);
          prod = pp_doubled(mode_q, row, j) ? (prod << 1) : prod;
          pp_col[CIW'(row + j)]     = pp_col[CIW'(row + j)] + ACC'(prod[WORD_LEN-1:0]);
          pp_col[CIW'(row + j + 1)] = pp_col[CIW'(row + j + 1)] + ACC'(prod >> WORD_LEN);
        end else begin
          prod = '0;
        end
      end
    end
    if (row_q == '0) begin
      for (int k = 0; k < N; k++) begin
        if (mode_q == MODE_HIGH) begin
          pp_col[CIW'(N + k)] = pp_col[CIW'(N + k)] + ACC'(add_q[k]);
        end else begin
          pp_col[CIW'(k)] = pp_col[CIW'(k)] + ACC'(add_q[k]);
        end
      end
    end else begin
      prod = '0;
    end
  end

  // Present the current window of accumulator columns to the carry slice.
  always_comb begin
    int w;
    w = 0;
    for (int k = 0; k < CW; k++) begin
      w = int'(cq_q) * CW + k;
      if (w < NCOL) begin
        slice_col[k] = acc_q[CIW'(w)];
        slice_top[k] = (w == NCOL - 1);
      end else begin
        slice_col[k] = '0;
        slice_top[k] = 1'b0;
      end
    end
  end

  redun_carry_prop #(
    .CARRY_WORDS (CW),
    .ACC_BIT_LEN (ACC),
    .WORD_LEN    (WORD_LEN),
    .DSP_BIT_LEN (DBL)
  ) u_carry_prop (
    .i_col   (slice_col),
    .i_top   (slice_top),
    .i_carry (carry_q),
    .o_word  (slice_word),
    .o_carry (slice_carry)
  );

  // Next-state logic: accept, MUL passes, CARRY windows, hold result until taken.
  always_comb begin
    int w;
    w       = 0;
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    add_d   = add_q;
    acc_d   = acc_q;
    dat_d   = dat_q;
    row_d   = row_q;
    cq_d    = cq_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (i_val && rdy_q) begin
          mode_d = mode_e'(i_ctl);
          for (int k = 0; k < N; k++) begin
            a_d[k]   = i_dat_a[k*DBL +: DBL];
            b_d[k]   = (mode_e'(i_ctl) == MODE_SQUARE) ? i_dat_a[k*DBL +: DBL]
                                                       : i_dat_b[k*DBL +: DBL];
            add_d[k] = i_add_term[k*DBL +: DBL];
          end
          for (int c = 0; c < NCOL; c++) acc_d[c] = '0;
          row_d   = '0;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        for (int c = 0; c < NCOL; c++) acc_d[c] = acc_q[c] + pp_col[c];
        if (row_q == RW'(P - 1)) begin
          cq_d    = '0;
          carry_d = '0;
          state_d = CARRY;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      CARRY: begin
        carry_d = slice_carry;
        for (int k = 0; k < CW; k++) begin
          w = int'(cq_q) * CW + k;
          if (w < NCOL) begin
            dat_d[CIW'(w)] = word_kept(mode_q, w, N) ? slice_word[k] : '0;
          end else begin
            w = 0;
          end
        end
        if (cq_q == CCW'(C - 1)) begin
          state_d = DONE;
        end else begin
          cq_d = cq_q + CCW'(1);
        end
      end
      DONE: begin
        if (i_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d  = (state_d == IDLE);
    val_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_LOW;
      row_q   <= '0;
      cq_q    <= '0;
      carry_q <= '0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        add_q[k] <= '0;
      end
      for (int c = 0; c < NCOL; c++) begin
        acc_q[c] <= '0;
        dat_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      cq_q    <= cq_d;
      carry_q <= carry_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      add_q   <= add_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
    end
  end

  for (genvar g = 0; g < NCOL; g++) begin : g_out
    assign o_dat[g*DBL +: DBL] = dat_q[g];
  end

  assign o_rdy  = rdy_q;
  assign o_val  = val_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_multi_mode_multiplier_iter.sv
// Directed-vector bench for multi_mode_multiplier_iter with N=4, one row per
// MUL cycle (P=4) and three words per CARRY cycle (C=3, last window partial).
module tb_multi_mode_multiplier_iter;
  import mmm_iter_pkg::*;

  localparam int N    = 4;
  localparam int DBL  = 17;
  localparam int WL   = 16;
  localparam int R    = 1;
  localparam int CW   = 3;
  localparam int OW   = 2 * N * DBL;
  // Rising edges from the accept edge until o_val is first seen high: P + C.
  localparam int LAT  = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_val;
  logic                 o_rdy;
  logic [1:0]           i_ctl;
  logic [N*DBL-1:0]     i_dat_a;
  logic [N*DBL-1:0]     i_dat_b;
  logic [N*DBL-1:0]     i_add_term;
  logic                 o_val;
  logic                 i_rdy;
  logic [OW-1:0]        o_dat;
  logic                 o_busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [N*DBL-1:0] a_red;
  logic [255:0]     v_sq;
  logic [255:0]     v_ones;

  multi_mode_multiplier_iter #(
    .NUM_ELEMENTS   (N),
    .DSP_BIT_LEN    (DBL),
    .WORD_LEN       (WL),
    .ROWS_PER_CYCLE (R),
    .CARRY_WORDS    (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .i_ctl      (i_ctl),
    .i_dat_a    (i_dat_a),
    .i_dat_b    (i_dat_b),
    .i_add_term (i_add_term),
    .o_val      (o_val),
    .i_rdy      (i_rdy),
    .o_dat      (o_dat),
    .o_busy     (o_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DBL-1:0] ops(input logic [16:0] w3, input logic [16:0] w2,
                                           input logic [16:0] w1, input logic [16:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [255:0] opval(input logic [N*DBL-1:0] v);
    logic [255:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + (256'(v[k*DBL +: DBL]) << (WL * k));
    return s;
  endfunction

  // Radix-2^16 words with the top word holding the remaining bits, 17 kept.
  function automatic logic [OW-1:0] packv(input logic [255:0] v);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < 2 * N - 1; k++) r[k*DBL +: DBL] = {1'b0, v[k*WL +: WL]};
    r[(2*N-1)*DBL +: DBL] = v[(2*N-1)*WL +: DBL];
    return r;
  endfunction

  task automatic start_op(input logic [1:0] mode, input logic [N*DBL-1:0] a,
                          input logic [N*DBL-1:0] b, input logic [N*DBL-1:0] add);
    @(negedge clk);
    i_val      = 1'b1;
    i_ctl      = mode;
    i_dat_a    = a;
    i_dat_b    = b;
    i_add_term = add;
    @(posedge clk);
    #1;
    i_val      = 1'b0;
    i_ctl      = 2'd0;
    i_dat_a    = '1;
    i_dat_b    = '1;
    i_add_term = '1;
  endtask

  task automatic wait_val(input string tag);
    int lat;
    lat = 0;
    while (o_val !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 256'(lat), 256'(LAT));
  endtask

  task automatic run_op(input string tag, input logic [1:0] mode, input logic [N*DBL-1:0] a,
                        input logic [N*DBL-1:0] b, input logic [N*DBL-1:0] add,
                        input logic [255:0] v_exp);
    start_op(mode, a, b, add);
    chk({tag, "_busy"}, 256'(o_busy), 256'(1'b1));
    wait_val(tag);
    chk({tag, "_dat"}, 256'(o_dat), 256'(packv(v_exp)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    i_val      = 1'b0;
    i_rdy      = 1'b1;
    i_ctl      = 2'd0;
    i_dat_a    = '0;
    i_dat_b    = '0;
    i_add_term = '0;
    #12;
    chk("rst_rdy",  256'(o_rdy),  256'(1'b1));
    chk("rst_val",  256'(o_val),  256'(1'b0));
    chk("rst_busy", 256'(o_busy), 256'(1'b0));
    chk("rst_dat",  256'(o_dat),  256'(0));
    @(negedge clk);
    rst = 1'b0;

    // (2^64-1)^2 = 2^128 - 2^65 + 1
    v_ones = 256'h0000_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    run_op("full_ones", MODE_FULL, ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF),
           ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF), '0, v_ones);
    chk("idle_rdy", 256'(o_rdy), 256'(1'b1));

    run_op("low_small", MODE_LOW, ops(17'd0, 17'd0, 17'd0, 17'd2),
           ops(17'd0, 17'd0, 17'd0, 17'd3), ops(17'd0, 17'd0, 17'd0, 17'd5), 256'd11);
    run_op("high_small", MODE_HIGH, ops(17'd0, 17'd0, 17'd0, 17'd2),
           ops(17'd0, 17'd0, 17'd0, 17'd3), '0, 256'd0);
    // HIGH places the add term at weight N: word 4 = 5
    run_op("high_add", MODE_HIGH, ops(17'd0, 17'd0, 17'd0, 17'd2),
           ops(17'd0, 17'd0, 17'd0, 17'd3), ops(17'd0, 17'd0, 17'd0, 17'd5),
           256'h5_0000_0000_0000_0000);
    // a3*b0 (i+j=3) kept in HIGH, a0*b0 dropped
    run_op("high_mix", MODE_HIGH, ops(17'h1234, 17'd0, 17'd0, 17'hFFFF),
           ops(17'd0, 17'd0, 17'd0, 17'h10), '0, 256'h1_2340_0000_0000_0000);
    // LOW keeps both products, result taken mod 2^64
    run_op("low_mix", MODE_LOW, ops(17'h1234, 17'd0, 17'd0, 17'hFFFF),
           ops(17'd0, 17'd0, 17'd0, 17'h10), '0, 256'h2340_0000_000F_FFF0);
    // (5 + 3*2^16)^2 = 25 + 30*2^16 + 9*2^32, B ignored
    run_op("sq_small", MODE_SQUARE, ops(17'd0, 17'd0, 17'd3, 17'd5),
           ops(17'h0DEAD, 17'h1BEEF, 17'h0CAFE, 17'h1F00D), '0, 256'h0009_001E_0019);

    a_red = ops(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
    v_sq  = opval(a_red) * opval(a_red);
    run_op("sq_red", MODE_SQUARE, a_red, ops(17'h12345, 17'h0ABCD, 17'h1F0F0, 17'h00777),
           '0, v_sq);
    run_op("full_red", MODE_FULL, a_red, a_red, '0, v_sq);
    // 7*9 + 0xFFFF + 2^48
    run_op("full_add", MODE_FULL, ops(17'd0, 17'd0, 17'd0, 17'd7),
           ops(17'd0, 17'd0, 17'd0, 17'd9), ops(17'd1, 17'd0, 17'd0, 17'hFFFF),
           256'h0001_0000_0001_003E);

    // Back-pressure: result held, new operands ignored while stalled.
    i_rdy = 1'b0;
    start_op(MODE_FULL, ops(17'd0, 17'd0, 17'd0, 17'd7), ops(17'd0, 17'd0, 17'd0, 17'd9),
             ops(17'd1, 17'd0, 17'd0, 17'hFFFF));
    wait_val("stall");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_val   = c[0];
      i_ctl   = MODE_LOW;
      i_dat_a = ops(17'd1, 17'd1, 17'd1, 17'd1);
      i_dat_b = ops(17'd2, 17'd2, 17'd2, 17'd2);
      @(posedge clk);
      #1;
      chk("stall_val", 256'(o_val), 256'(1'b1));
      chk("stall_rdy", 256'(o_rdy), 256'(1'b0));
      chk("stall_dat", 256'(o_dat), 256'(packv(256'h0001_0000_0001_003E)));
    end
    @(negedge clk);
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("release_val",  256'(o_val),  256'(1'b0));
    chk("release_rdy",  256'(o_rdy),  256'(1'b1));
    chk("release_busy", 256'(o_busy), 256'(1'b0));
    run_op("after_stall", MODE_LOW, ops(17'd0, 17'd0, 17'd0, 17'd2),
           ops(17'd0, 17'd0, 17'd0, 17'd3), ops(17'd0, 17'd0, 17'd0, 17'd5), 256'd11);

    // Reset in the third MUL cycle aborts the operation asynchronously.
    start_op(MODE_FULL, ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF),
             ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF), '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 256'(o_busy), 256'(1'b1));
    rst = 1'b1;
    #1;
    chk("abort_val",  256'(o_val),  256'(1'b0));
    chk("abort_busy", 256'(o_busy), 256'(1'b0));
    chk("abort_rdy",  256'(o_rdy),  256'(1'b1));
    chk("abort_dat",  256'(o_dat),  256'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", MODE_FULL, ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF),
           ops(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF), '0, v_ones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
